// File: rtl/lfsr_stream_pkg.sv
// Shared types and constants for the lfsr_stream word generator:
// FSM encoding, default feedback mask and the substitute used for a zero seed.
package lfsr_stream_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // x^64 + x^63 + x^61 + x^60 + 1
  localparam logic [63:0] DEF_TAPS      = 64'hD800_0000_0000_0000;
  localparam int unsigned ZERO_SEED_SUB = 1;

endpackage

// File: rtl/lfsr_stream_if.sv
// Output word stream: the producer holds lfsr/valid until the consumer raises ready.
interface lfsr_stream_if #(
  parameter int WIDTH = 64
);
  logic [WIDTH-1:0] lfsr;
  logic             valid;
  logic             ready;

  modport master (output lfsr, output valid, input ready);
  modport slave  (input lfsr, input valid, output ready);
endinterface

// File: rtl/lfsr_stream_step.sv
// One Galois LFSR shift, purely combinational; chained to build multi-step advances.
module lfsr_stream_step #(
  parameter int               WIDTH = 64,
  parameter logic [WIDTH-1:0] TAPS  = '0
) (
  input  logic [WIDTH-1:0] s_i,
  output logic [WIDTH-1:0] s_o
);

  assign s_o = (s_i >> 1) ^ (s_i[0] ? TAPS : '0);

endmodule

// File: rtl/lfsr_stream.sv
// Seeded LFSR word generator: first word one cycle after start, one word per accepted cycle.
// Stalls losslessly while ready is low; stop or the last accept ends the run with a done pulse.
module lfsr_stream
  import lfsr_stream_pkg::*;
#(
  parameter int               WIDTH   = 64,
  parameter logic [WIDTH-1:0] TAPS    = WIDTH'(DEF_TAPS),
  parameter int               STEPS   = 1,
  parameter int               COUNT_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic               stop_i,
  input  logic [WIDTH-1:0]   message_seed_i,
  input  logic [COUNT_W-1:0] count_i,
  output logic               busy_o,
  output logic               done_o,
  lfsr_stream_if.master      out_if
);

  state_e             state_q;
  logic [WIDTH-1:0]   lfsr_q;
  logic [WIDTH-1:0]   lfsr_d;
  logic               valid_q;
  logic               busy_q;
  logic               done_q;
  logic [COUNT_W-1:0] rem_q;
  logic               free_q;
  logic               accept;

  logic [WIDTH-1:0] chain [0:STEPS];

  assign chain[0] = lfsr_q;

  for (genvar g = 0; g < STEPS; g++) begin : g_step
    lfsr_stream_step #(
      .WIDTH (WIDTH),
      .TAPS  (TAPS)
    ) u_step (
      .s_i (chain[g]),
      .s_o (chain[g+1])
    );
  end

  assign lfsr_d = chain[STEPS];
  assign accept = valid_q && out_if.ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      lfsr_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rem_q   <= '0;
      free_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            // An all-zero state would lock the LFSR, so substitute a non-zero seed.
            lfsr_q  <= (message_seed_i == '0) ? WIDTH'(ZERO_SEED_SUB) : message_seed_i;
            rem_q   <= count_i;
            free_q  <= (count_i == '0);
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (stop_i) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end else if (accept) begin
            lfsr_q <= lfsr_d;
            if (!free_q && rem_q == COUNT_W'(1)) begin
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_IDLE;
            end else if (!free_q) begin
              rem_q <= rem_q - COUNT_W'(1);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign out_if.lfsr  = lfsr_q;
  assign out_if.valid = valid_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;

endmodule

// File: tb/tb_lfsr_stream.sv
// Scoreboard bench: stimulus queues expected words, per-instance monitors pop on each handshake.
module tb_lfsr_stream;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [63:0] qa[$];
  logic [63:0] qb[$];
  logic [63:0] qc[$];

  // u_a: WIDTH=8 STEPS=1, u_b: WIDTH=8 STEPS=2, u_c: default 64-bit
  logic        a_start = 0, a_stop = 0, a_busy, a_done;
  logic [7:0]  a_seed = 0;
  logic [31:0] a_cnt = 0;
  logic        b_start = 0, b_stop = 0, b_busy, b_done;
  logic [7:0]  b_seed = 0;
  logic [31:0] b_cnt = 0;
  logic        c_start = 0, c_stop = 0, c_busy, c_done;
  logic [63:0] c_seed = 0;
  logic [31:0] c_cnt = 0;

  lfsr_stream_if #(.WIDTH(8))  a_if();
  lfsr_stream_if #(.WIDTH(8))  b_if();
  lfsr_stream_if #(.WIDTH(64)) c_if();

  lfsr_stream #(.WIDTH(8), .TAPS(8'hB8), .STEPS(1), .COUNT_W(32)) u_a (
    .clk(clk), .rst_n(rst_n), .start_i(a_start), .stop_i(a_stop),
    .message_seed_i(a_seed), .count_i(a_cnt), .busy_o(a_busy), .done_o(a_done),
    .out_if(a_if));

  lfsr_stream #(.WIDTH(8), .TAPS(8'hB8), .STEPS(2), .COUNT_W(32)) u_b (
    .clk(clk), .rst_n(rst_n), .start_i(b_start), .stop_i(b_stop),
    .message_seed_i(b_seed), .count_i(b_cnt), .busy_o(b_busy), .done_o(b_done),
    .out_if(b_if));

  lfsr_stream u_c (
    .clk(clk), .rst_n(rst_n), .start_i(c_start), .stop_i(c_stop),
    .message_seed_i(c_seed), .count_i(c_cnt), .busy_o(c_busy), .done_o(c_done),
    .out_if(c_if));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [63:0] act);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got unexpected word %h, expected none", name, act);
  endtask

  function automatic logic [63:0] gstep(input logic [63:0] s, input logic [63:0] taps);
    return (s >> 1) ^ (s[0] ? taps : 64'h0);
  endfunction

  always @(negedge clk) begin
    if (a_if.valid && a_if.ready) begin
      if (qa.size() == 0) unexpected("a_word", {56'h0, a_if.lfsr});
      else chk("a_word", {56'h0, a_if.lfsr}, qa.pop_front());
    end
    if (b_if.valid && b_if.ready) begin
      if (qb.size() == 0) unexpected("b_word", {56'h0, b_if.lfsr});
      else chk("b_word", {56'h0, b_if.lfsr}, qb.pop_front());
    end
    if (c_if.valid && c_if.ready) begin
      if (qc.size() == 0) unexpected("c_word", c_if.lfsr);
      else chk("c_word", c_if.lfsr, qc.pop_front());
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [63:0] s;
    bit seen;
    a_if.ready = 0;
    b_if.ready = 0;
    c_if.ready = 0;
    #12;
    chk("rst_a_valid", {63'h0, a_if.valid}, 64'h0);
    chk("rst_a_lfsr", {56'h0, a_if.lfsr}, 64'h0);
    chk("rst_c_lfsr", c_if.lfsr, 64'h0);
    chk("rst_busy_done", {62'h0, c_busy, c_done}, 64'h0);
    rst_n = 1;
    tick();

    // 1: STEPS=1 count=6
    a_seed = 8'h01; a_cnt = 6; a_start = 1; a_if.ready = 1;
    qa.push_back(64'h01); qa.push_back(64'hB8); qa.push_back(64'h5C);
    qa.push_back(64'h2E); qa.push_back(64'h17); qa.push_back(64'hB3);
    tick();
    a_start = 0;
    chk("t1_first_word", {56'h0, a_if.lfsr}, 64'h01);
    chk("t1_busy", {63'h0, a_busy}, 64'h1);
    repeat (6) tick();
    chk("t1_done_valid_busy", {61'h0, a_done, a_if.valid, a_busy}, 64'h4);
    tick();
    chk("t1_done_low", {63'h0, a_done}, 64'h0);
    chk("t1_queue_empty", 64'(qa.size()), 64'h0);
    a_if.ready = 0;

    // 2: STEPS=2 count=4
    b_seed = 8'h01; b_cnt = 4; b_start = 1; b_if.ready = 1;
    qb.push_back(64'h01); qb.push_back(64'h5C); qb.push_back(64'h17); qb.push_back(64'hE1);
    tick();
    b_start = 0;
    repeat (4) tick();
    chk("t2_done", {62'h0, b_done, b_if.valid}, 64'h2);
    chk("t2_queue_empty", 64'(qb.size()), 64'h0);
    b_if.ready = 0;

    // 3: zero seed substitution
    a_seed = 8'h00; a_cnt = 2; a_start = 1; a_if.ready = 1;
    qa.push_back(64'h01); qa.push_back(64'hB8);
    tick();
    a_start = 0;
    chk("t3_sub_seed", {56'h0, a_if.lfsr}, 64'h01);
    repeat (2) tick();
    chk("t3_done", {63'h0, a_done}, 64'h1);
    chk("t3_queue_empty", 64'(qa.size()), 64'h0);
    a_if.ready = 0;
    tick();

    // 4: free-running, stall, ignored start, full period, stop
    a_seed = 8'h01; a_cnt = 0; a_start = 1; a_if.ready = 1;
    qa.push_back(64'h01); qa.push_back(64'hB8); qa.push_back(64'h5C);
    s = 64'h5C;
    for (int i = 3; i < 255; i++) begin
      s = gstep(s, 64'hB8);
      qa.push_back(s);
    end
    qa.push_back(64'h01);
    tick();
    a_start = 0;
    tick();
    a_if.ready = 0;
    for (int i = 0; i < 3; i++) begin
      chk("t4_hold_word", {56'h0, a_if.lfsr}, 64'hB8);
      chk("t4_hold_valid", {63'h0, a_if.valid}, 64'h1);
      if (i == 1) begin a_start = 1; a_seed = 8'h55; a_cnt = 3; end
      else a_start = 0;
      tick();
    end
    a_start = 0;
    a_if.ready = 1;
    repeat (255) tick();
    chk("t4_period_queue", 64'(qa.size()), 64'h0);
    chk("t4_still_busy", {63'h0, a_busy}, 64'h1);
    a_if.ready = 0; a_stop = 1;
    tick();
    a_stop = 0;
    chk("t4_stop_done", {61'h0, a_done, a_busy, a_if.valid}, 64'h4);
    tick();
    chk("t4_done_low", {63'h0, a_done}, 64'h0);

    // 5: 64-bit default configuration, 1000 words
    c_seed = 64'h9084_0000_8080_0000; c_cnt = 1000; c_start = 1; c_if.ready = 1;
    qc.push_back(64'h9084_0000_8080_0000);
    qc.push_back(64'h4842_0000_4040_0000);
    qc.push_back(64'h2421_0000_2020_0000);
    s = 64'h2421_0000_2020_0000;
    for (int i = 3; i < 1000; i++) begin
      s = gstep(s, 64'hD800_0000_0000_0000);
      qc.push_back(s);
    end
    tick();
    c_start = 0;
    seen = 0;
    for (int i = 0; i < 1200 && !seen; i++) begin
      tick();
      if (c_done) seen = 1;
    end
    chk("t5_done_seen", {63'h0, seen}, 64'h1);
    chk("t5_queue_empty", 64'(qc.size()), 64'h0);
    c_if.ready = 0;

    // 6: reset mid-run
    a_seed = 8'h01; a_cnt = 10; a_start = 1; a_if.ready = 1;
    qa.push_back(64'h01); qa.push_back(64'hB8); qa.push_back(64'h5C);
    tick();
    a_start = 0;
    repeat (3) tick();
    a_if.ready = 0;
    rst_n = 0;
    #1;
    chk("t6_rst_outputs", {a_if.lfsr, a_if.valid, a_busy, a_done}, 64'h0);
    tick();
    rst_n = 1;
    repeat (2) begin
      chk("t6_no_done", {62'h0, a_done, a_busy}, 64'h0);
      tick();
    end
    chk("t6_queue_empty", 64'(qa.size()), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
